// File: rtl/btn_step_gen.sv
// Pushbutton conditioner: 2-flop synchronizer, debounce FSM, registered one-cycle
// step pulse per accepted press, optional auto-repeat while held.
module btn_step_gen #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_EN       = 0,
  parameter int REPEAT_DELAY    = 500,
  parameter int REPEAT_PERIOD   = 100
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic step,
  output logic pressed
);

  localparam int DBW     = $clog2(DEBOUNCE_CYCLES);
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW      = $clog2(RPT_MAX);

  localparam logic [DBW-1:0] DB_LAST  = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0]  DLY_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0]  PER_LAST = RW'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {IDLE, DB_PRESS, HELD, DB_RELEASE} state_t;

  state_t           state, state_d;
  logic             s1, btn_s;
  logic [DBW-1:0]   db_cnt, db_cnt_d;
  logic [RW-1:0]    rpt_cnt, rpt_cnt_d;
  logic             rpt_first, rpt_first_d;
  logic             rpt_tick;
  logic             step_d, pressed_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1    <= 1'b0;
      btn_s <= 1'b0;
    end else begin
      s1    <= btn;
      btn_s <= s1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      db_cnt    <= '0;
      rpt_cnt   <= '0;
      rpt_first <= 1'b0;
      step      <= 1'b0;
      pressed   <= 1'b0;
    end else begin
      state     <= state_d;
      db_cnt    <= db_cnt_d;
      rpt_cnt   <= rpt_cnt_d;
      rpt_first <= rpt_first_d;
      step      <= step_d;
      pressed   <= pressed_d;
    end
  end

  always_comb begin
    state_d     = state;
    db_cnt_d    = db_cnt;
    rpt_cnt_d   = rpt_cnt;
    rpt_first_d = rpt_first;
    rpt_tick    = 1'b0;
    step_d      = 1'b0;
    pressed_d   = pressed;
    unique case (state)
      IDLE: begin
        pressed_d = 1'b0;
        if (btn_s) begin
          state_d  = DB_PRESS;
          db_cnt_d = DBW'(1);
        end
      end
      DB_PRESS: begin
        if (!btn_s) begin
          state_d = IDLE;
        end else if (db_cnt == DB_LAST) begin
          state_d     = HELD;
          step_d      = 1'b1;
          pressed_d   = 1'b1;
          rpt_cnt_d   = '0;
          rpt_first_d = 1'b1;
        end else begin
          db_cnt_d = db_cnt + DBW'(1);
        end
      end
      HELD: begin
        if (!btn_s) begin
          state_d  = DB_RELEASE;
          db_cnt_d = DBW'(1);
        end else begin
          rpt_tick = 1'b1;
        end
      end
      DB_RELEASE: begin
        // A re-press counts as a held cycle, so the repeat schedule slips by
        // exactly the cycles spent here.
        if (btn_s) begin
          state_d  = HELD;
          rpt_tick = 1'b1;
        end else if (db_cnt == DB_LAST) begin
          state_d   = IDLE;
          pressed_d = 1'b0;
        end else begin
          db_cnt_d = db_cnt + DBW'(1);
        end
      end
    endcase

    // First repeat waits REPEAT_DELAY held cycles, later ones REPEAT_PERIOD.
    if (REPEAT_EN != 0 && rpt_tick) begin
      if (rpt_cnt == (rpt_first ? DLY_LAST : PER_LAST)) begin
        step_d      = 1'b1;
        rpt_cnt_d   = '0;
        rpt_first_d = 1'b0;
      end else begin
        rpt_cnt_d = rpt_cnt + RW'(1);
      end
    end
  end

endmodule

// File: tb/tb_btn_step_gen.sv
// Bench for btn_step_gen: three configurations driven side by side and compared
// every cycle against a run-length/held-count model of the button.
module tb_btn_step_gen;
  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] btn;
  logic [2:0] step_w, pressed_w;
  logic [2:0] cnt7;

  always #5 clk = ~clk;

  btn_step_gen #(.DEBOUNCE_CYCLES(4), .REPEAT_EN(0)) u0 (
    .clk(clk), .reset(reset), .btn(btn[0]), .step(step_w[0]), .pressed(pressed_w[0]));
  btn_step_gen #(.DEBOUNCE_CYCLES(4), .REPEAT_EN(1), .REPEAT_DELAY(20), .REPEAT_PERIOD(8)) u1 (
    .clk(clk), .reset(reset), .btn(btn[1]), .step(step_w[1]), .pressed(pressed_w[1]));
  btn_step_gen #(.DEBOUNCE_CYCLES(2), .REPEAT_EN(0)) u2 (
    .clk(clk), .reset(reset), .btn(btn[2]), .step(step_w[2]), .pressed(pressed_w[2]));

  // mod-7 counter advanced by the D=2 instance
  always @(posedge clk or posedge reset)
    if (reset) cnt7 <= 3'd0;
    else if (step_w[2]) cnt7 <= (cnt7 == 3'd6) ? 3'd0 : cnt7 + 3'd1;

  int errors = 0, checks = 0;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model: a press/release is accepted after D consecutive synchronized
  // samples disagreeing with the accepted level; repeats fire when the number of
  // held samples since acceptance hits DELAY, DELAY+PERIOD, DELAY+2*PERIOD, ...
  int MD[3]   = '{4, 4, 2};
  int MREN[3] = '{0, 1, 0};
  int MDEL[3] = '{500, 20, 500};
  int MPER[3] = '{100, 8, 100};
  bit m_s1[3], m_bs[3], m_lvl[3], m_step[3];
  int m_run[3], m_ticks[3];

  always @(posedge clk or posedge reset) begin
    for (int i = 0; i < 3; i++) begin
      if (reset) begin
        m_s1[i] = 0; m_bs[i] = 0; m_lvl[i] = 0; m_step[i] = 0;
        m_run[i] = 0; m_ticks[i] = 0;
      end else begin
        m_step[i] = 0;
        if (m_bs[i] != m_lvl[i]) begin
          m_run[i]++;
          if (m_run[i] == MD[i]) begin
            m_lvl[i]   = m_bs[i];
            m_run[i]   = 0;
            m_ticks[i] = 0;
            m_step[i]  = m_lvl[i];
          end
        end else begin
          m_run[i] = 0;
          if (m_lvl[i] && MREN[i] != 0) begin
            m_ticks[i]++;
            if (m_ticks[i] >= MDEL[i] && (m_ticks[i] - MDEL[i]) % MPER[i] == 0)
              m_step[i] = 1;
          end
        end
        m_bs[i] = m_s1[i];
        m_s1[i] = btn[i];
      end
    end
  end

  int cyc_n = 0, st0_n, st0_at, st2_n, pr0_fall;
  int q1[$];
  bit pr0_prev = 0;

  task automatic cyc();
    @(posedge clk);
    #1;
    cyc_n++;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("step%0d@%0d", i, cyc_n), int'(step_w[i]), int'(m_step[i]));
      chk($sformatf("pressed%0d@%0d", i, cyc_n), int'(pressed_w[i]), int'(m_lvl[i]));
    end
    if (step_w[0]) begin st0_n++; st0_at = cyc_n; end
    if (pr0_prev && !pressed_w[0]) pr0_fall = cyc_n;
    pr0_prev = pressed_w[0];
    if (step_w[1]) q1.push_back(cyc_n);
    if (step_w[2]) st2_n++;
  endtask

  int a;
  int pat[7] = '{1, 1, 1, 0, 1, 1, 0};
  int rexp[6] = '{0, 20, 28, 36, 44, 52};
  int rem[3], lv[3], age[3];

  initial begin
    btn = 3'b000;
    reset = 1'b1;
    repeat (3) cyc();
    chk("rst_step", int'(step_w), 0);
    chk("rst_pressed", int'(pressed_w), 0);
    reset = 1'b0;
    repeat (2) cyc();

    // clean press on D=4, held 20 cycles
    st0_n = 0; a = cyc_n + 1; btn[0] = 1'b1;
    repeat (20) cyc();
    btn[0] = 1'b0;
    repeat (15) cyc();
    chk("press_nstep", st0_n, 1);
    chk("press_at", st0_at, a + 5);
    chk("release_at", pr0_fall, a + 25);

    // glitches then a stable press
    st0_n = 0;
    foreach (pat[k]) begin btn[0] = pat[k][0]; cyc(); end
    a = cyc_n + 1; btn[0] = 1'b1;
    repeat (15) cyc();
    btn[0] = 1'b0;
    repeat (12) cyc();
    chk("glitch_nstep", st0_n, 1);
    chk("glitch_at", st0_at, a + 5);

    // auto-repeat schedule
    q1.delete(); a = cyc_n + 1; btn[1] = 1'b1;
    repeat (60) cyc();
    btn[1] = 1'b0;
    repeat (20) cyc();
    chk("rpt_nstep", q1.size(), 6);
    for (int k = 0; k < 6 && k < q1.size(); k++)
      chk($sformatf("rpt_at%0d", k), q1[k], a + 5 + rexp[k]);

    // 2-cycle release glitch while held delays repeats by 2
    q1.delete(); btn[1] = 1'b1;
    for (int k = 0; k < 60 && q1.size() < 2; k++) cyc();
    chk("gap_pre", q1.size(), 2);
    btn[1] = 1'b0; cyc(); cyc();
    btn[1] = 1'b1;
    repeat (20) cyc();
    btn[1] = 1'b0;
    repeat (15) cyc();
    chk("gap_nstep", q1.size() >= 3, 1);
    if (q1.size() >= 3) chk("gap_delay", q1[2] - q1[1], 10);

    // reset in DB_PRESS (u0) while u1 is held
    btn[1] = 1'b1;
    repeat (10) cyc();
    btn[0] = 1'b1;
    repeat (3) cyc();
    reset = 1'b1;
    #1;
    chk("rst_async_pr1", int'(pressed_w[1]), 0);
    chk("rst_async_step", int'(step_w), 0);
    cyc();
    reset = 1'b0;
    st0_n = 0; a = cyc_n + 1;
    repeat (12) cyc();
    chk("rst_nstep", st0_n, 1);
    chk("rst_at", st0_at, a + 5);
    btn = 3'b000;
    repeat (15) cyc();

    // random bouncing levels on all three
    for (int i = 0; i < 3; i++) begin rem[i] = 0; lv[i] = 0; age[i] = 0; end
    repeat (1500) begin
      for (int i = 0; i < 3; i++) begin
        if (rem[i] == 0) begin
          lv[i] ^= 1; rem[i] = $urandom_range(1, 45); age[i] = 0;
        end
        btn[i] = (age[i] < 3 && $urandom_range(0, 1) == 1) ? ~lv[i][0] : lv[i][0];
        age[i]++; rem[i]--;
      end
      cyc();
    end
    btn = 3'b000;
    repeat (15) cyc();

    // nine clean presses into the mod-7 counter
    reset = 1'b1; cyc(); reset = 1'b0; cyc();
    st2_n = 0;
    for (int k = 1; k <= 9; k++) begin
      btn[2] = 1'b1; repeat (6) cyc();
      btn[2] = 1'b0; repeat (6) cyc();
      chk($sformatf("mod7_%0d", k), int'(cnt7), k % 7);
    end
    chk("mod7_nstep", st2_n, 9);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
